// File: rtl/iop_mem_arbiter.sv
// Round-robin arbiter merging NCH IOP load/store ports onto one shared memory bus,
// one outstanding transaction at a time, with a bus watchdog and sticky per-channel timeout flags.
module iop_mem_arbiter #(
    parameter int NCH     = 2,
    parameter int AW      = 24,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              sysclk,
    input  logic              sysrst,
    input  logic [NCH-1:0]    ch_read,
    input  logic [NCH-1:0]    ch_write,
    input  logic [NCH*AW-1:0] ch_raddr,
    input  logic [NCH*AW-1:0] ch_waddr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [DW-1:0]     ch_rdata,
    output logic [NCH-1:0]    ch_rrdy,
    output logic [NCH-1:0]    ch_wrdy,
    output logic [NCH-1:0]    ch_err,
    input  logic [NCH-1:0]    err_clr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam bit WD_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   rr_ptr_q;
    logic [GW-1:0]   gnt_q;
    logic [CW-1:0]   cnt_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [DW-1:0]   rdata_q;
    logic [NCH-1:0]  rrdy_q;
    logic [NCH-1:0]  wrdy_q;
    logic [NCH-1:0]  err_q;

    logic [NCH-1:0]  pending;
    logic            gnt_vld_d;
    logic [GW-1:0]   gnt_d;
    logic [GW-1:0]   cand_idx;
    int              cand;
    logic            gnt_we_d;
    logic [AW-1:0]   gnt_addr_d;
    logic [DW-1:0]   gnt_wdata_d;
    logic            wd_expire;
    logic [NCH-1:0]  err_set_d;
    logic [NCH-1:0]  err_d;

    assign pending = ch_read | ch_write;

    // Scan starts just after the last grant so every requester gets a turn.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_d     = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NCH;
            cand_idx = GW'(cand);
            if (!gnt_vld_d && pending[cand_idx]) begin
                gnt_vld_d = 1'b1;
                gnt_d     = cand_idx;
            end
        end
    end

    // A channel with both strobes high is served as a write first.
    always_comb begin
        gnt_we_d    = 1'b0;
        gnt_addr_d  = '0;
        gnt_wdata_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_d == GW'(i)) begin
                gnt_we_d    = ch_write[i];
                gnt_addr_d  = ch_write[i] ? ch_waddr[i*AW +: AW] : ch_raddr[i*AW +: AW];
                gnt_wdata_d = ch_wdata[i*DW +: DW];
            end
        end
    end

    assign wd_expire = WD_EN && (cnt_q == CNT_LAST);

    // An ack landing in the expiry cycle completes normally and flags nothing.
    always_comb begin
        err_set_d = '0;
        if (state_q == BUSY && !mem_ack && wd_expire) begin
            err_set_d[gnt_q] = 1'b1;
        end
    end

    assign err_d = (err_q & ~err_clr) | err_set_d;

    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= GW'(NCH - 1);
            gnt_q       <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            rrdy_q      <= '0;
            wrdy_q      <= '0;
        end else begin
            rrdy_q <= '0;
            wrdy_q <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        gnt_q       <= gnt_d;
                        rr_ptr_q    <= gnt_d;
                        mem_we_q    <= gnt_we_d;
                        mem_addr_q  <= gnt_addr_d;
                        mem_wdata_q <= gnt_wdata_d;
                        mem_req_q   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack || wd_expire) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                        if (mem_we_q) begin
                            wrdy_q[gnt_q] <= 1'b1;
                        end else begin
                            rrdy_q[gnt_q] <= 1'b1;
                            rdata_q       <= mem_ack ? mem_rdata : '1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ch_rdata  = rdata_q;
    assign ch_rrdy   = rrdy_q;
    assign ch_wrdy   = wrdy_q;
    assign ch_err    = err_q;

endmodule

// File: tb/tb_iop_mem_arbiter.sv
// Bench for iop_mem_arbiter: vector table plus scoreboard, with a behavioural slave RAM and requesters.
`timescale 1ns/1ps
module tb_iop_mem_arbiter;

    localparam int NCH = 2;
    localparam int AW  = 24;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic              sysclk = 1'b0;
    logic              sysrst;
    logic [NCH-1:0]    ch_read;
    logic [NCH-1:0]    ch_write;
    logic [NCH*AW-1:0] ch_raddr;
    logic [NCH*AW-1:0] ch_waddr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [DW-1:0]     ch_rdata;
    logic [NCH-1:0]    ch_rrdy;
    logic [NCH-1:0]    ch_wrdy;
    logic [NCH-1:0]    ch_err;
    logic [NCH-1:0]    err_clr;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata;

    always #5 sysclk = ~sysclk;

    iop_mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .sysclk    (sysclk),
        .sysrst    (sysrst),
        .ch_read   (ch_read),
        .ch_write  (ch_write),
        .ch_raddr  (ch_raddr),
        .ch_waddr  (ch_waddr),
        .ch_wdata  (ch_wdata),
        .ch_rdata  (ch_rdata),
        .ch_rrdy   (ch_rrdy),
        .ch_wrdy   (ch_wrdy),
        .ch_err    (ch_err),
        .err_clr   (err_clr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        int          ch;
        bit          wr;
        logic [23:0] addr;
        logic [7:0]  wdata;
        int          swait;
        logic [7:0]  rdata;
        int          busy;
        logic [1:0]  err;
        int          gap;
    } txn_t;

    txn_t        sb[$];
    txn_t        vecs[6];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_rdy = 0;
    int          req_cnt = 0;
    int          slv_cnt = 0;
    int          slave_wait = 0;
    int          wr_left[2];
    int          rd_left[2];
    logic [23:0] cap_addr;
    logic        cap_we;
    logic [7:0]  cap_wdata;
    logic [7:0]  ram[256];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_strobes();
        ch_read  = {rd_left[1] > 0, rd_left[0] > 0};
        ch_write = {wr_left[1] > 0, wr_left[0] > 0};
    endtask

    task automatic set_ch(input int ch, input bit wr, input logic [23:0] addr, input logic [7:0] wd);
        if (ch == 0) begin
            if (wr) begin
                ch_waddr[23:0] = addr;
                ch_wdata[7:0]  = wd;
            end else begin
                ch_raddr[23:0] = addr;
            end
        end else begin
            if (wr) begin
                ch_waddr[47:24] = addr;
                ch_wdata[15:8]  = wd;
            end else begin
                ch_raddr[47:24] = addr;
            end
        end
    endtask

    // One clock: observe just after the edge, then update requesters and the slave.
    task automatic tick();
        txn_t e;
        @(posedge sysclk);
        #1;
        cyc++;
        if (mem_req) begin
            if (req_cnt == 0) begin
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
            end
            req_cnt++;
        end
        if (ch_rrdy != '0 || ch_wrdy != '0) begin
            if (sb.size() == 0) begin
                check("spurious_rdy", 64'({ch_rrdy, ch_wrdy}), 64'(0));
            end else begin
                e = sb.pop_front();
                check("rrdy", 64'(ch_rrdy), e.wr ? 64'(0) : (64'(1) << e.ch));
                check("wrdy", 64'(ch_wrdy), e.wr ? (64'(1) << e.ch) : 64'(0));
                check("mem_we", 64'(cap_we), 64'(e.wr));
                check("mem_addr", 64'(cap_addr), 64'(e.addr));
                if (e.wr) check("mem_wdata", 64'(cap_wdata), 64'(e.wdata));
                else      check("ch_rdata", 64'(ch_rdata), 64'(e.rdata));
                check("req_cycles", 64'(req_cnt), 64'(e.busy));
                check("ch_err", 64'(ch_err), 64'(e.err));
                if (e.gap > 0) check("rdy_gap", 64'(cyc - last_rdy), 64'(e.gap));
            end
            req_cnt  = 0;
            last_rdy = cyc;
            if (ch_rrdy[0] && rd_left[0] > 0) rd_left[0]--;
            if (ch_rrdy[1] && rd_left[1] > 0) rd_left[1]--;
            if (ch_wrdy[0] && wr_left[0] > 0) wr_left[0]--;
            if (ch_wrdy[1] && wr_left[1] > 0) wr_left[1]--;
        end
        drive_strobes();
        if (mem_req) begin
            if (slave_wait >= 0 && slv_cnt == slave_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = ram[mem_addr[7:0]];
                if (mem_we) ram[mem_addr[7:0]] = mem_wdata;
            end else begin
                mem_ack = 1'b0;
            end
            slv_cnt++;
        end else begin
            mem_ack = 1'b0;
            slv_cnt = 0;
        end
    endtask

    task automatic run_txns(input int bound);
        int i = 0;
        while (sb.size() != 0 && i < bound) begin
            tick();
            i++;
        end
        if (sb.size() != 0) begin
            check("txn_bound", 64'(sb.size()), 64'(0));
            sb.delete();
        end
        tick();
    endtask

    task automatic apply(input txn_t t);
        set_ch(t.ch, t.wr, t.addr, t.wdata);
        slave_wait = t.swait;
        if (t.wr) wr_left[t.ch] = 1;
        else      rd_left[t.ch] = 1;
        sb.push_back(t);
        drive_strobes();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int i;
        txn_t t;
        for (int k = 0; k < 256; k++) ram[k] = 8'(k) ^ 8'h55;
        ram[8'h34] = 8'hA5;
        wr_left[0] = 0; wr_left[1] = 0; rd_left[0] = 0; rd_left[1] = 0;
        sysrst = 1'b0; err_clr = '0; mem_ack = 1'b0; mem_rdata = '0;
        ch_raddr = '0; ch_waddr = '0; ch_wdata = '0;
        drive_strobes();

        vecs[0] = '{ch:0, wr:1'b0, addr:24'h001234, wdata:8'h00, swait:0,  rdata:8'hA5, busy:1, err:2'b00, gap:0};
        vecs[1] = '{ch:1, wr:1'b1, addr:24'h000456, wdata:8'h3C, swait:0,  rdata:8'h00, busy:1, err:2'b00, gap:0};
        vecs[2] = '{ch:1, wr:1'b0, addr:24'h000456, wdata:8'h00, swait:2,  rdata:8'h3C, busy:3, err:2'b00, gap:0};
        vecs[3] = '{ch:0, wr:1'b1, addr:24'hABCDEF, wdata:8'hC3, swait:1,  rdata:8'h00, busy:2, err:2'b00, gap:0};
        vecs[4] = '{ch:0, wr:1'b0, addr:24'h0000EF, wdata:8'h00, swait:3,  rdata:8'hC3, busy:4, err:2'b00, gap:0};
        vecs[5] = '{ch:0, wr:1'b0, addr:24'h000077, wdata:8'h00, swait:-1, rdata:8'hFF, busy:4, err:2'b01, gap:0};

        tick();
        tick();
        check("rst_mem_req",   64'(mem_req),   64'(0));
        check("rst_mem_we",    64'(mem_we),    64'(0));
        check("rst_mem_addr",  64'(mem_addr),  64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_ch_rdata",  64'(ch_rdata),  64'(0));
        check("rst_rdy",       64'({ch_rrdy, ch_wrdy}), 64'(0));
        check("rst_ch_err",    64'(ch_err),    64'(0));
        sysrst = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            apply(vecs[v]);
            run_txns(40);
        end

        tick(); tick(); tick();
        check("err_sticky", 64'(ch_err), 64'(2'b01));
        err_clr = 2'b01;
        tick();
        err_clr = 2'b00;
        check("err_cleared", 64'(ch_err), 64'(0));

        // Timeout on ch0 while err_clr[0] is held: the set must win on that edge.
        err_clr = 2'b01;
        t = '{ch:0, wr:1'b0, addr:24'h000055, wdata:8'h00, swait:-1, rdata:8'hFF, busy:4, err:2'b01, gap:0};
        apply(t);
        run_txns(40);
        err_clr = 2'b00;
        check("err_after_setclr", 64'(ch_err), 64'(0));

        // Reset while BUSY: outputs drop without a clock and the transfer is dropped.
        slave_wait = -1;
        set_ch(0, 1'b0, 24'h000100, 8'h00);
        rd_left[0] = 1;
        drive_strobes();
        i = 0;
        while (!mem_req && i < 10) begin
            tick();
            i++;
        end
        check("busy_before_reset", 64'(mem_req), 64'(1));
        #2 sysrst = 1'b0;
        #1;
        check("async_rst_mem_req",  64'(mem_req),  64'(0));
        check("async_rst_rdy",      64'({ch_rrdy, ch_wrdy}), 64'(0));
        check("async_rst_mem_addr", 64'(mem_addr), 64'(0));
        check("async_rst_rdata",    64'(ch_rdata), 64'(0));
        sb.delete();
        req_cnt = 0;
        slave_wait = 0;
        set_ch(0, 1'b0, 24'h000144, 8'h00);
        set_ch(1, 1'b0, 24'h000233, 8'h00);
        rd_left[0] = 1;
        rd_left[1] = 1;
        sb.push_back('{ch:0, wr:1'b0, addr:24'h000144, wdata:8'h00, swait:0, rdata:8'h11, busy:1, err:2'b00, gap:0});
        sb.push_back('{ch:1, wr:1'b0, addr:24'h000233, wdata:8'h00, swait:0, rdata:8'h66, busy:1, err:2'b00, gap:3});
        drive_strobes();
        tick();
        tick();
        sysrst = 1'b1;
        run_txns(40);

        // Both channels keep writing: grants must alternate, one completion every 3 cycles.
        set_ch(0, 1'b1, 24'h000020, 8'h11);
        set_ch(1, 1'b1, 24'h000021, 8'h22);
        wr_left[0] = 2;
        wr_left[1] = 2;
        slave_wait = 0;
        sb.push_back('{ch:0, wr:1'b1, addr:24'h000020, wdata:8'h11, swait:0, rdata:8'h00, busy:1, err:2'b00, gap:0});
        sb.push_back('{ch:1, wr:1'b1, addr:24'h000021, wdata:8'h22, swait:0, rdata:8'h00, busy:1, err:2'b00, gap:3});
        sb.push_back('{ch:0, wr:1'b1, addr:24'h000020, wdata:8'h11, swait:0, rdata:8'h00, busy:1, err:2'b00, gap:3});
        sb.push_back('{ch:1, wr:1'b1, addr:24'h000021, wdata:8'h22, swait:0, rdata:8'h00, busy:1, err:2'b00, gap:3});
        drive_strobes();
        run_txns(60);

        // Write and read raised together on ch1 to the same byte: write goes first.
        set_ch(1, 1'b1, 24'h000010, 8'h5A);
        set_ch(1, 1'b0, 24'h000010, 8'h00);
        wr_left[1] = 1;
        rd_left[1] = 1;
        sb.push_back('{ch:1, wr:1'b1, addr:24'h000010, wdata:8'h5A, swait:0, rdata:8'h00, busy:1, err:2'b00, gap:0});
        sb.push_back('{ch:1, wr:1'b0, addr:24'h000010, wdata:8'h00, swait:0, rdata:8'h5A, busy:1, err:2'b00, gap:3});
        drive_strobes();
        run_txns(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
